ysyx_22040237_ifu: RTL and testbench

//  Instruction fetch unit: the producer end of the decode interface. Owns the PC and

---
 rtl/ysyx_22040237_ifu.sv | 131 +++++++++++++
 tb/tb_ysyx_22040237_ifu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// hands {inst, pc} to the decoder over a valid/ready handshake, honouring redirects.
module ysyx_22040237_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [31:0] inst_q;
    logic        drop_q;
    logic        req_valid_q;
    logic        inst_valid_q;

    logic [63:0] redirect_tgt;
    logic        unused_low_bits;

    // Instructions are word aligned, so the low target bits are discarded.
    assign redirect_tgt    = {redirect_pc_i[63:2], 2'b00};
    assign unused_low_bits = ^redirect_pc_i[1:0];

    assign imem_req_valid_o = req_valid_q;
    assign imem_addr_o      = pc_q;
    assign inst_valid_o     = inst_valid_q;
    assign inst_o           = inst_q;
    assign pc_o             = pc_q;

    // Fetch FSM; the valid outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q      <= S_REQ;
                    req_valid_q  <= 1'b1;
                    inst_valid_q <= 1'b0;
                end
                S_REQ: begin
                    if (redirect_i) begin
                        pc_q <= redirect_tgt;
                        if (imem_req_ready_i) begin
                            // The accepted request targets the old PC; its data must be thrown away.
                            drop_q      <= 1'b1;
                            state_q     <= S_WAIT;
                            req_valid_q <= 1'b0;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end else if (imem_req_ready_i) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (drop_q || redirect_i) begin
                            drop_q      <= 1'b0;
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            if (redirect_i) begin
                                pc_q <= redirect_tgt;
                            end else begin
                                pc_q <= pc_q;
                            end
                        end else begin
                            inst_q       <= imem_rsp_data_i;
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                        end
                    end else if (redirect_i) begin
                        pc_q   <= redirect_tgt;
                        drop_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    // A redirect outranks consumption: the buffered instruction is on the wrong path.
                    if (redirect_i) begin
                        pc_q         <= redirect_tgt;
                        state_q      <= S_REQ;
                        req_valid_q  <= 1'b1;
                        inst_valid_q <= 1'b0;
                    end else if (inst_ready_i) begin
                        pc_q         <= pc_q + 64'd4;
                        state_q      <= S_REQ;
                        req_valid_q  <= 1'b1;
                        inst_valid_q <= 1'b0;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    drop_q       <= 1'b0;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Scoreboard bench for the fetch unit: directed stimulus pushes expected request
// addresses and delivered instructions; a negedge monitor pops and compares on handshakes.
module tb_ysyx_22040237_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;

    int checks;
    int failures;

    logic [63:0] exp_addr_q[$];
    logic [95:0] exp_inst_q[$];

    ysyx_22040237_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every request and instruction handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid_o && imem_req_ready_i) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_req", {32'h0, imem_addr_o}, 96'h0);
                end else begin
                    chk("req_addr", {32'h0, imem_addr_o}, {32'h0, exp_addr_q.pop_front()});
                end
            end
            if (inst_valid_o && inst_ready_i && !redirect_i) begin
                if (exp_inst_q.size() == 0) begin
                    chk("unexpected_inst", {inst_o, pc_o}, 96'h0);
                end else begin
                    chk("inst_pc", {inst_o, pc_o}, exp_inst_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [63:0] addr);
        int n;
        n = 0;
        while (!imem_req_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req_valid_o) chk("req_timeout", 96'h0, 96'h1);
        exp_addr_q.push_back(addr);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
    endtask

    task automatic do_rsp(input logic [31:0] data);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = data;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
    endtask

    task automatic do_accept(input logic [31:0] inst, input logic [63:0] pc);
        int n;
        n = 0;
        while (!inst_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!inst_valid_o) chk("inst_timeout", 96'h0, 96'h1);
        exp_inst_q.push_back({inst, pc});
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        inst_ready_i     = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 64'h0;

        // 1: reset state, IDLE for one cycle, then first request
        repeat (3) tick();
        chk("rst_req_valid", {95'h0, imem_req_valid_o}, 96'h0);
        chk("rst_inst_valid", {95'h0, inst_valid_o}, 96'h0);
        chk("rst_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0000});
        chk("rst_pc", {32'h0, pc_o}, {32'h0, 64'h8000_0000});
        chk("rst_inst", {64'h0, inst_o}, 96'h0);
        rst = 1'b0;
        chk("idle_req_valid", {95'h0, imem_req_valid_o}, 96'h0);
        tick();
        chk("first_req_valid", {95'h0, imem_req_valid_o}, 96'h1);
        chk("first_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0000});

        // 2: zero-wait fetch, latency check, accept
        do_req(64'h8000_0000);
        chk("wait_inst_valid", {95'h0, inst_valid_o}, 96'h0);
        do_rsp(32'h0010_0093);
        chk("hold_inst_valid", {95'h0, inst_valid_o}, 96'h1);
        chk("hold_inst", {64'h0, inst_o}, {64'h0, 32'h0010_0093});
        chk("hold_pc", {32'h0, pc_o}, {32'h0, 64'h8000_0000});
        do_accept(32'h0010_0093, 64'h8000_0000);
        chk("next_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0004});
        chk("next_req_valid", {95'h0, imem_req_valid_o}, 96'h1);

        // 3: hold with stall and a stray response
        do_req(64'h8000_0004);
        do_rsp(32'h0020_0113);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i = 32'hDEAD_BEEF;
            tick();
            imem_rsp_valid_i = 1'b0;
            chk("stall_inst", {inst_o, pc_o}, {32'h0020_0113, 64'h8000_0004});
            chk("stall_req_valid", {94'h0, imem_req_valid_o, inst_valid_o}, 96'h1);
        end
        do_accept(32'h0020_0113, 64'h8000_0004);
        chk("after_stall_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0008});

        // 4: redirect in WAIT (unaligned target), late response dropped
        do_req(64'h8000_0008);
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h8000_0103;
        tick();
        redirect_i = 1'b0;
        chk("wait_redir_req_valid", {95'h0, imem_req_valid_o}, 96'h0);
        tick();
        do_rsp(32'hBAD0_0001);
        chk("dropped_inst_valid", {95'h0, inst_valid_o}, 96'h0);
        chk("redir_addr", {95'h0, imem_req_valid_o}, 96'h1);
        chk("redir_addr_val", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0100});

        // 5: redirect and ready together in HOLD
        do_req(64'h8000_0100);
        do_rsp(32'h0030_0193);
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h8000_0200;
        inst_ready_i  = 1'b1;
        tick();
        redirect_i   = 1'b0;
        inst_ready_i = 1'b0;
        chk("hold_redir_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0200});
        chk("hold_redir_valid", {94'h0, imem_req_valid_o, inst_valid_o}, 96'h2);

        // REQ redirect without ready, then redirect with ready (drop in flight)
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h8000_0300;
        tick();
        chk("req_redir_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0300});
        redirect_pc_i = 64'h8000_0400;
        exp_addr_q.push_back(64'h8000_0300);
        imem_req_ready_i = 1'b1;
        tick();
        redirect_i       = 1'b0;
        imem_req_ready_i = 1'b0;
        do_rsp(32'hBAD0_0002);
        chk("req_drop_inst_valid", {95'h0, inst_valid_o}, 96'h0);
        chk("req_drop_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0400});

        // response and redirect in the same WAIT cycle
        do_req(64'h8000_0400);
        redirect_i    = 1'b1;
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        do_rsp(32'hBAD0_0003);
        redirect_i = 1'b0;
        chk("rsp_redir_inst_valid", {95'h0, inst_valid_o}, 96'h0);
        chk("rsp_redir_addr", {32'h0, imem_addr_o}, {32'h0, 64'hFFFF_FFFF_FFFF_FFFC});

        // PC wrap
        do_req(64'hFFFF_FFFF_FFFF_FFFC);
        do_rsp(32'h0000_0013);
        do_accept(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", {32'h0, imem_addr_o}, 96'h0);

        // 6: reset during WAIT, late response after release is ignored
        do_req(64'h0);
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hBAD0_0004;
        tick();
        imem_rsp_valid_i = 1'b0;
        chk("post_rst_inst_valid", {95'h0, inst_valid_o}, 96'h0);
        chk("post_rst_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0000});
        do_req(64'h8000_0000);
        do_rsp(32'h0040_0213);
        do_accept(32'h0040_0213, 64'h8000_0000);
        chk("post_rst_next_addr", {32'h0, imem_addr_o}, {32'h0, 64'h8000_0004});

        tick();
        chk("addr_q_empty", {64'h0, 32'(exp_addr_q.size())}, 96'h0);
        chk("inst_q_empty", {64'h0, 32'(exp_inst_q.size())}, 96'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
